pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Game sequencer for FPGA Pong.
- Owns the ball position and velocity, serves, scoring and game-over.
- Gates both paddle instances through a shared `pad_en` and consumes their top/mid/bottom hit flags to steer the ball.
- Sits between the frame-tick generator, the two paddles and the ball/score renderers.

Parameters:
- BALL_SIZE, 10, ball edge length in pixels.
- TOP_BOUND, 136, top wall y; ball_y never goes below this.
- BOTTOM_BOUND, 512, bottom wall y; ball_y+BALL_SIZE never exceeds this.
- LEFT_EDGE, 0, left goal line x.
- RIGHT_EDGE, 799, right goal line x.
- BALL_X0, 395, centre x used on serve and reset.
- BALL_Y0, 319, centre y used on serve and reset.
- XSPEED, 2, horizontal pixels per frame.
- YSPEED, 2, vertical pixels per frame after an off-centre hit.
- SERVE_FRAMES, 60, frames the ball is held at centre before play.
- WIN_SCORE, 7, points needed to win.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  start/restart request (level; sampled each cycle).
- l_tophit, l_midhit, l_bothit  in  1 each  left paddle hit flags.
- r_tophit, r_midhit, r_bothit  in  1 each  right paddle hit flags.
- pad_en  out  1  paddle enable.
- ball_x  out  10  ball left edge.
- ball_y  out  10  ball top edge.
- score_l  out  4  left score.
- score_r  out  4  right score.
- serving  out  1  high in SERVE.
- game_over  out  1  high in GAME_OVER.

Behaviour:
- Reset (reset=0, async, any state):
  - state=IDLE, ball_x=BALL_X0, ball_y=BALL_Y0.
  - dx=+XSPEED, dy=0.
  - scores=0, serve counter=0.
  - All 1-bit outputs 0.
- dx and dy are signed internally; position arithmetic is 11-bit signed so LEFT_EDGE/TOP_BOUND comparisons cannot wrap.
- All outputs are registered except pad_en, serving and game_over, which decode the state directly.
- Motion, counter and score updates occur only on cycles with frame_tick=1. State transitions caused by start occur on any cycle.
- IDLE: ball at centre. start=1 -> SERVE, counter=SERVE_FRAMES.
- SERVE:
  - serving=1; ball held at BALL_X0/BALL_Y0; dy=0.
  - Each frame_tick decrements the counter. The tick that takes the counter to 0 enters PLAY, so PLAY begins on the SERVE_FRAMES-th tick.
- PLAY:
  - pad_en=1. Per frame_tick, resolve in this priority:
  - 1. Paddle hit. Left flags count only when dx<0; right flags count only when dx>0 (flags on the receding side are ignored).
    - Any counted flag reverses the sign of dx.
    - dy becomes -YSPEED for top, 0 for mid, +YSPEED for bottom.
    - If several flags are set: top > bottom > mid.
    - x then moves by the new dx.
  - 2. Miss, evaluated only if there is no hit:
    - dx<0 and ball_x+dx <= LEFT_EDGE -> right scores.
    - dx>0 and ball_x+dx+BALL_SIZE >= RIGHT_EDGE -> left scores.
    - On a miss, go to SCORE with no position update.
  - 3. Otherwise ball_x += dx.
  - 4. Wall, evaluated in the same tick:
    - ball_y+dy <= TOP_BOUND -> ball_y=TOP_BOUND, dy=+|dy|.
    - ball_y+dy+BALL_SIZE >= BOTTOM_BOUND -> ball_y=BOTTOM_BOUND-BALL_SIZE, dy=-|dy|.
    - Otherwise ball_y += dy.
- SCORE (one clock, no tick needed):
  - Increment the scorer's count, saturating at WIN_SCORE.
  - If the new score equals WIN_SCORE -> GAME_OVER.
  - Otherwise -> SERVE with counter=SERVE_FRAMES, ball recentred, and dx pointing toward the player who conceded (magnitude XSPEED).
- GAME_OVER:
  - game_over=1, pad_en=0, ball frozen.
  - start=1 -> clear both scores, recentre, dx=+XSPEED, SERVE.
- start is ignored in SERVE, PLAY and SCORE.
- frame_tick in IDLE or GAME_OVER has no effect.

Test Plan:
- Hold reset=0 mid-PLAY. Required: ball_x=395, ball_y=319, scores 0 and pad_en=0 immediately, with no clock edge; state=IDLE after release.
- Pulse start, then issue 60 frame_ticks. Required: serving=1 through tick 59; PLAY with pad_en=1 on tick 60; ball_x=397 after tick 61.
- In PLAY with dx=-2 and dy=0, assert l_tophit with frame_tick. Required: dx=+2, dy=-2, ball_x +2. Asserting r_midhit at the same time has no effect.
- Ball at y=138 with dy=-2. Required: next tick gives y=136, dy=+2. At y=501 with dy=+2, next tick gives y=502, dy=-2.
- Left-moving ball with no hits until ball_x<=2. Required: score_r 0->1, SERVE, ball at (395,319), dx=-2.
- Drive score_l to 7. Required: game_over=1, pad_en=0. start then clears scores and serving=1.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game sequencer. Owns the ball position and
// velocity, serve countdown, scoring, game-over and the paddle enable.
//
// Ports:
//   clk, reset (async, active-low)
//   frame_tick  one-cycle pulse per video frame
//   start       start / restart request (level)
//   l_*hit      left paddle top/mid/bottom hit flags
//   r_*hit      right paddle top/mid/bottom hit flags
//   pad_en      paddle enable (high in PLAY)
//   ball_x/y    ball top-left corner
//   score_l/r   scores
//   serving     high in SERVE
//   game_over   high in GAME_OVER
module pong_game_ctrl #(
    parameter int BALL_SIZE    = 10,
    parameter int TOP_BOUND    = 136,
    parameter int BOTTOM_BOUND = 512,
    parameter int LEFT_EDGE    = 0,
    parameter int RIGHT_EDGE   = 799,
    parameter int BALL_X0      = 395,
    parameter int BALL_Y0      = 319,
    parameter int XSPEED       = 2,
    parameter int YSPEED       = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       l_tophit,
    input  logic       l_midhit,
    input  logic       l_bothit,
    input  logic       r_tophit,
    input  logic       r_midhit,
    input  logic       r_bothit,
    output logic       pad_en,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       serving,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_SCORE,
        S_OVER
    } state_t;

    // Position math is 11-bit signed so edge compares cannot wrap.
    localparam logic signed [10:0] BS  = 11'(BALL_SIZE);
    localparam logic signed [10:0] TB  = 11'(TOP_BOUND);
    localparam logic signed [10:0] BB  = 11'(BOTTOM_BOUND);
    localparam logic signed [10:0] LE  = 11'(LEFT_EDGE);
    localparam logic signed [10:0] RE  = 11'(RIGHT_EDGE);
    localparam logic signed [10:0] XS  = 11'(XSPEED);
    localparam logic signed [10:0] YS  = 11'(YSPEED);
    localparam logic [9:0]         X0  = 10'(BALL_X0);
    localparam logic [9:0]         Y0  = 10'(BALL_Y0);
    localparam logic [7:0]         SF  = 8'(SERVE_FRAMES);
    localparam logic [3:0]         WIN = 4'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [9:0]         bx_q, bx_d;
    logic [9:0]         by_q, by_d;
    logic signed [10:0] dx_q, dx_d;
    logic signed [10:0] dy_q, dy_d;
    logic [3:0]         sl_q, sl_d;
    logic [3:0]         sr_q, sr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               rsc_q, rsc_d;

    logic               l_act, r_act;
    logic               hit_top, hit_bot, hit_mid, hit;
    logic signed [10:0] px, py;
    logic signed [10:0] ndx, ndy, ady;
    logic signed [10:0] nx, ny;
    logic [3:0]         new_sc;

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        rsc_d   = rsc_q;

        // Only flags on the side the ball approaches are counted.
        l_act   = dx_q < 0;
        r_act   = dx_q > 0;
        hit_top = (l_act & l_tophit) | (r_act & r_tophit);
        hit_bot = (l_act & l_bothit) | (r_act & r_bothit);
        hit_mid = (l_act & l_midhit) | (r_act & r_midhit);
        hit     = hit_top | hit_bot | hit_mid;

        px  = signed'({1'b0, bx_q});
        py  = signed'({1'b0, by_q});
        ndx = hit ? -dx_q : dx_q;
        ndy = dy_q;
        if (hit_top) begin
            ndy = -YS;
        end else if (hit_bot) begin
            ndy = YS;
        end else if (hit_mid) begin
            ndy = '0;
        end
        ady = ndy[10] ? -ndy : ndy;
        nx  = px + ndx;
        ny  = py + ndy;

        new_sc = '0;

        unique case (state_q)
            S_IDLE: begin
                bx_d = X0;
                by_d = Y0;
                if (start) begin
                    state_d = S_SERVE;
                    cnt_d   = SF;
                end
            end

            S_SERVE: begin
                bx_d = X0;
                by_d = Y0;
                dy_d = '0;
                if (frame_tick) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = '0;
                        state_d = S_PLAY;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            S_PLAY: begin
                if (frame_tick) begin
                    if (!hit && dx_q < 0 && nx <= LE) begin
                        rsc_d   = 1'b1;
                        state_d = S_SCORE;
                    end else if (!hit && dx_q > 0
                                 && nx + BS >= RE) begin
                        rsc_d   = 1'b0;
                        state_d = S_SCORE;
                    end else begin
                        dx_d = ndx;
                        bx_d = nx[9:0];
                        if (ny <= TB) begin
                            by_d = TB[9:0];
                            dy_d = ady;
                        end else if (ny + BS >= BB) begin
                            by_d = 10'(BB - BS);
                            dy_d = -ady;
                        end else begin
                            by_d = ny[9:0];
                            dy_d = ndy;
                        end
                    end
                end
            end

            S_SCORE: begin
                if (rsc_q) begin
                    new_sc = (sr_q >= WIN) ? WIN : sr_q + 4'd1;
                    sr_d   = new_sc;
                    // Serve toward the player who conceded.
                    dx_d   = -XS;
                end else begin
                    new_sc = (sl_q >= WIN) ? WIN : sl_q + 4'd1;
                    sl_d   = new_sc;
                    dx_d   = XS;
                end
                if (new_sc == WIN) begin
                    state_d = S_OVER;
                end else begin
                    state_d = S_SERVE;
                    cnt_d   = SF;
                    bx_d    = X0;
                    by_d    = Y0;
                    dy_d    = '0;
                end
            end

            S_OVER: begin
                if (start) begin
                    sl_d    = '0;
                    sr_d    = '0;
                    bx_d    = X0;
                    by_d    = Y0;
                    dx_d    = XS;
                    dy_d    = '0;
                    cnt_d   = SF;
                    state_d = S_SERVE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            bx_q    <= X0;
            by_q    <= Y0;
            dx_q    <= XS;
            dy_q    <= '0;
            sl_q    <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            rsc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            rsc_q   <= rsc_d;
        end
    end

    assign pad_en    = (state_q == S_PLAY);
    assign serving   = (state_q == S_SERVE);
    assign game_over = (state_q == S_OVER);
    assign ball_x    = bx_q;
    assign ball_y    = by_q;
    assign score_l   = sl_q;
    assign score_r   = sr_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scoreboard bench for pong_game_ctrl.
// Stimulus pushes expected outputs; a monitor pops and compares.
module tb_pong_game_ctrl;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       l_tophit, l_midhit, l_bothit;
    logic       r_tophit, r_midhit, r_bothit;
    logic       pad_en;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       serving;
    logic       game_over;

    localparam logic [5:0] NH = 6'b000000;
    localparam logic [5:0] LT = 6'b100000;
    localparam logic [5:0] LM = 6'b010000;
    localparam logic [5:0] LB = 6'b001000;
    localparam logic [5:0] RT = 6'b000100;
    localparam logic [5:0] RM = 6'b000010;
    localparam logic [5:0] RB = 6'b000001;

    typedef struct {
        string      name;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       pe;
        logic       sv;
        logic       go;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    pong_game_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .start     (start),
        .l_tophit  (l_tophit),
        .l_midhit  (l_midhit),
        .l_bothit  (l_bothit),
        .r_tophit  (r_tophit),
        .r_midhit  (r_midhit),
        .r_bothit  (r_bothit),
        .pad_en    (pad_en),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .score_l   (score_l),
        .score_r   (score_r),
        .serving   (serving),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every falling edge, compare all pending expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if ({ball_x, ball_y, score_l, score_r,
                     pad_en, serving, game_over} !==
                    {e.x, e.y, e.sl, e.sr, e.pe, e.sv, e.go}) begin
                    errors++;
                    $display({"FAIL %s: got x=%0d y=%0d sl=%0d sr=%0d",
                              " pe=%b sv=%b go=%b; want x=%0d y=%0d",
                              " sl=%0d sr=%0d pe=%b sv=%b go=%b"},
                             e.name, ball_x, ball_y, score_l, score_r,
                             pad_en, serving, game_over, e.x, e.y,
                             e.sl, e.sr, e.pe, e.sv, e.go);
                end
            end
        end
    end

    task automatic expect_out(input string n, input int x, input int y,
                              input int sl, input int sr, input logic pe,
                              input logic sv, input logic go);
        exp_t e;
        e.name = n;
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.sl   = 4'(sl);
        e.sr   = 4'(sr);
        e.pe   = pe;
        e.sv   = sv;
        e.go   = go;
        expq.push_back(e);
    endtask

    task automatic cyc(input logic t, input logic s, input logic [5:0] h);
        @(negedge clk);
        frame_tick = t;
        start      = s;
        {l_tophit, l_midhit, l_bothit,
         r_tophit, r_midhit, r_bothit} = h;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
        {l_tophit, l_midhit, l_bothit,
         r_tophit, r_midhit, r_bothit} = NH;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, NH);
    endtask

    initial begin
        reset      = 1'b0;
        frame_tick = 1'b0;
        start      = 1'b0;
        {l_tophit, l_midhit, l_bothit,
         r_tophit, r_midhit, r_bothit} = NH;

        #2;
        expect_out("reset_state", 395, 319, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        cyc(1'b1, 1'b0, NH);
        expect_out("idle_tick_ignored", 395, 319, 0, 0, 0, 0, 0);
        cyc(1'b0, 1'b1, NH);
        expect_out("start_to_serve", 395, 319, 0, 0, 0, 1, 0);

        for (int i = 1; i <= 59; i++) begin
            cyc(1'b1, 1'b0, NH);
            if (i == 1 || i == 59)
                expect_out("serve_hold", 395, 319, 0, 0, 0, 1, 0);
        end
        cyc(1'b1, 1'b0, NH);
        expect_out("play_on_tick60", 395, 319, 0, 0, 1, 0, 0);
        cyc(1'b1, 1'b0, NH);
        expect_out("first_move", 397, 319, 0, 0, 1, 0, 0);

        cyc(1'b1, 1'b0, RM | LT);
        expect_out("r_mid_hit", 395, 319, 0, 0, 1, 0, 0);
        cyc(1'b1, 1'b0, LT | RM);
        expect_out("l_top_hit", 397, 317, 0, 0, 1, 0, 0);
        cyc(1'b1, 1'b0, RB);
        expect_out("r_bot_hit", 395, 319, 0, 0, 1, 0, 0);

        ticks(91);
        expect_out("reach_y501", 213, 501, 0, 0, 1, 0, 0);
        cyc(1'b1, 1'b0, NH);
        expect_out("bottom_clamp", 211, 502, 0, 0, 1, 0, 0);
        cyc(1'b1, 1'b0, NH);
        expect_out("bottom_bounce", 209, 500, 0, 0, 1, 0, 0);

        cyc(1'b1, 1'b0, LT | LB | RT);
        expect_out("top_beats_bot", 211, 498, 0, 0, 1, 0, 0);
        ticks(180);
        expect_out("reach_y138", 571, 138, 0, 0, 1, 0, 0);
        cyc(1'b1, 1'b0, NH);
        expect_out("top_clamp", 573, 136, 0, 0, 1, 0, 0);
        cyc(1'b1, 1'b0, NH);
        expect_out("top_bounce", 575, 138, 0, 0, 1, 0, 0);

        cyc(1'b1, 1'b0, RM);
        expect_out("r_mid_flat", 573, 138, 0, 0, 1, 0, 0);
        ticks(286);
        expect_out("reach_x1", 1, 138, 0, 0, 1, 0, 0);
        cyc(1'b1, 1'b0, NH);
        expect_out("left_miss", 1, 138, 0, 0, 0, 0, 0);
        cyc(1'b0, 1'b1, NH);
        expect_out("right_scores", 395, 319, 0, 1, 0, 1, 0);

        ticks(60);
        cyc(1'b1, 1'b0, NH);
        expect_out("serve_dir_left", 393, 319, 0, 1, 1, 0, 0);
        cyc(1'b1, 1'b0, LM);
        expect_out("l_mid_hit", 395, 319, 0, 1, 1, 0, 0);
        ticks(196);
        expect_out("reach_x787", 787, 319, 0, 1, 1, 0, 0);
        cyc(1'b1, 1'b1, NH);
        expect_out("right_miss", 787, 319, 0, 1, 0, 0, 0);
        cyc(1'b0, 1'b0, NH);
        expect_out("left_scores", 395, 319, 1, 1, 0, 1, 0);

        for (int p = 2; p <= 7; p++) begin
            ticks(61);
            expect_out("serve_dir_right", 397, 319, p - 1, 1, 1, 0, 0);
            ticks(195);
            cyc(1'b1, 1'b0, NH);
            cyc(1'b0, 1'b0, NH);
            if (p < 7)
                expect_out("left_point", 395, 319, p, 1, 0, 1, 0);
            else
                expect_out("game_over", 787, 319, 7, 1, 0, 0, 1);
        end

        cyc(1'b1, 1'b0, NH);
        expect_out("over_frozen", 787, 319, 7, 1, 0, 0, 1);
        cyc(1'b0, 1'b1, NH);
        expect_out("restart", 395, 319, 0, 0, 0, 1, 0);
        ticks(61);
        expect_out("restart_dx", 397, 319, 0, 0, 1, 0, 0);
        ticks(195);
        cyc(1'b1, 1'b0, NH);
        cyc(1'b0, 1'b0, NH);
        expect_out("left_point_again", 395, 319, 1, 0, 0, 1, 0);
        ticks(61);
        expect_out("play_again", 397, 319, 1, 0, 1, 0, 0);
        ticks(2);

        #1;
        reset = 1'b0;
        expect_out("async_reset_play", 395, 319, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b1, 1'b0, NH);
        expect_out("idle_after_reset", 395, 319, 0, 0, 0, 0, 0);

        repeat (4) @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
